// File: rtl/etc_block_pixel_sequencer.sv
// etc_block_pixel_sequencer: walks the 16 texels of one ETC2 block through the decoder
// request handshake and streams the captured colours out as a backpressured pixel stream.
module etc_block_pixel_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit RASTER_ORDER   = 1'b1
) (
    input  logic        sclk,
    input  logic        rsrt,
    input  logic        blk_valid,
    output logic        blk_ready,
    input  logic [63:0] blk_data,
    input  logic        blk_flags,
    output logic [63:0] dec_block,
    output logic        dec_flags,
    output logic        dec_rtr,
    output logic [3:0]  dec_pix_idx,
    input  logic        dec_color_rts,
    input  logic [7:0]  dec_r,
    input  logic [7:0]  dec_g,
    input  logic [7:0]  dec_b,
    input  logic [7:0]  dec_a,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [31:0] pix_rgba,
    output logic [1:0]  pix_x,
    output logic [1:0]  pix_y,
    output logic        pix_last,
    output logic        busy,
    output logic        err_timeout
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   block_q, block_d;
    logic [31:0]   rgba_q, rgba_d;
    logic [1:0]    x_q, x_d, y_q, y_d;
    logic          flags_q, flags_d, valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [1:0]    cur_x, cur_y;
    logic          timed_out;

    // n counts in output order; the texel index is always {x,y}
    assign cur_x     = RASTER_ORDER ? n_q[1:0] : n_q[3:2];
    assign cur_y     = RASTER_ORDER ? n_q[3:2] : n_q[1:0];
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    assign blk_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign dec_rtr     = (state_q == REQ);
    assign dec_pix_idx = {cur_x, cur_y};
    assign dec_block   = block_q;
    assign dec_flags   = flags_q;
    assign pix_valid   = valid_q;
    assign pix_rgba    = rgba_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_last    = last_q;
    assign err_timeout = err_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        block_d = block_q;
        flags_d = flags_q;
        rgba_d  = rgba_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (blk_valid) begin
                block_d = blk_data;
                flags_d = blk_flags;
                n_d     = '0;
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (dec_color_rts) begin
                    rgba_d  = {dec_r, dec_g, dec_b, dec_a};
                    x_d     = cur_x;
                    y_d     = cur_y;
                    valid_d = 1'b1;
                    last_d  = (n_q == 4'd15);
                    state_d = OUT;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUT: if (pix_ready) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                cnt_d   = '0;
                if (n_q == 4'd15) begin
                    state_d = IDLE;
                end else begin
                    n_d     = n_q + 4'd1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            block_q <= '0;
            flags_q <= 1'b0;
            rgba_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
            flags_q <= flags_d;
            rgba_q  <= rgba_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_etc_block_pixel_sequencer.sv
// tb_etc_block_pixel_sequencer: drives a raster-order and a column-order sequencer from a
// behavioural decoder and compares the emitted pixel streams with the expected texel walk.
module tb_etc_block_pixel_sequencer;
    typedef struct packed {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [31:0] rgba;
        logic        last;
    } pix_t;

    logic        sclk = 1'b0;
    logic        rsrt = 1'b0;
    logic        blk_valid [2];
    logic        blk_ready [2];
    logic [63:0] blk_data [2];
    logic        blk_flags [2];
    logic [63:0] dec_block [2];
    logic        dec_flags [2];
    logic        dec_rtr [2];
    logic [3:0]  dec_pix_idx [2];
    logic        dec_color_rts [2];
    logic [7:0]  dec_r [2];
    logic [7:0]  dec_g [2];
    logic [7:0]  dec_b [2];
    logic [7:0]  dec_a [2];
    logic        pix_valid [2];
    logic        pix_ready [2];
    logic [31:0] pix_rgba [2];
    logic [1:0]  pix_x [2];
    logic [1:0]  pix_y [2];
    logic        pix_last [2];
    logic        busy [2];
    logic        err_timeout [2];

    int lat [2];
    int hang [2];
    logic spur [2];
    logic [31:0] spur_col;
    int wcnt [2];
    logic rtr_prev [2];
    int rise_cyc [2];
    int last_acc_cyc;
    int cyc = 0;
    pix_t got [$];
    logic [3:0] idxs [$];
    int checks = 0;
    int fails = 0;

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gen
        etc_block_pixel_sequencer #(.TIMEOUT_CYCLES(64), .RASTER_ORDER(g == 0)) u (
            .sclk(sclk), .rsrt(rsrt),
            .blk_valid(blk_valid[g]), .blk_ready(blk_ready[g]), .blk_data(blk_data[g]),
            .blk_flags(blk_flags[g]), .dec_block(dec_block[g]), .dec_flags(dec_flags[g]),
            .dec_rtr(dec_rtr[g]), .dec_pix_idx(dec_pix_idx[g]), .dec_color_rts(dec_color_rts[g]),
            .dec_r(dec_r[g]), .dec_g(dec_g[g]), .dec_b(dec_b[g]), .dec_a(dec_a[g]),
            .pix_valid(pix_valid[g]), .pix_ready(pix_ready[g]), .pix_rgba(pix_rgba[g]),
            .pix_x(pix_x[g]), .pix_y(pix_y[g]), .pix_last(pix_last[g]),
            .busy(busy[g]), .err_timeout(err_timeout[g])
        );
    end

    // Stand-in for the real decoder: any deterministic colour per (block, texel) will do
    function automatic logic [31:0] ref_col(input logic [63:0] b, input int i);
        return 32'(b >> (i * 2)) ^ {8{4'(i)}};
    endfunction

    // The n-th pixel a sequencer should emit for a block
    function automatic pix_t exp_pix(input int d, input logic [63:0] b, input int n);
        int x, y;
        x = (d == 0) ? n % 4 : n / 4;
        y = (d == 0) ? n / 4 : n % 4;
        return '{x: 2'(x), y: 2'(y), rgba: ref_col(b, x * 4 + y), last: n == 15};
    endfunction

    function automatic int exp_idx(input int d, input int n);
        return (d == 0) ? (n % 4) * 4 + n / 4 : n;
    endfunction

    // Decoder model and stream monitor, both sampled on the falling edge
    always @(negedge sclk) begin
        for (int d = 0; d < 2; d++) begin
            if (pix_valid[d] && pix_ready[d]) begin
                got.push_back({pix_x[d], pix_y[d], pix_rgba[d], pix_last[d]});
                last_acc_cyc = cyc;
            end
            if (dec_rtr[d] && !rtr_prev[d]) begin
                idxs.push_back(dec_pix_idx[d]);
                rise_cyc[d] = cyc;
            end
            rtr_prev[d] = dec_rtr[d];
            wcnt[d] = (dec_rtr[d] && int'(dec_pix_idx[d]) != hang[d]) ? wcnt[d] + 1 : 0;
            if (dec_rtr[d]) begin
                dec_color_rts[d] = (wcnt[d] == lat[d]);
                {dec_r[d], dec_g[d], dec_b[d], dec_a[d]} = ref_col(dec_block[d], int'(dec_pix_idx[d]));
            end else begin
                dec_color_rts[d] = spur[d];
                {dec_r[d], dec_g[d], dec_b[d], dec_a[d]} = spur_col;
            end
        end
    end

    task automatic send_block(input int d, input logic [63:0] b, input logic f);
        @(posedge sclk); #1;
        blk_valid[d] = 1'b1;
        blk_data[d] = b;
        blk_flags[d] = f;
        @(posedge sclk); #1;
        blk_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge sclk);
            if (!busy[d]) break;
        end
        if (busy[d]) begin
            checks++; fails++;
            $display("FAIL wait_idle dut%0d: busy=%b after %0d cycles, required 0", d, busy[d], bound);
        end
    endtask

    task automatic wait_valid(input int d, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge sclk);
            if (pix_valid[d]) break;
        end
        if (!pix_valid[d]) begin
            checks++; fails++;
            $display("FAIL wait_valid dut%0d: pix_valid=0 after %0d cycles, required 1", d, bound);
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({blk_ready[d], busy[d], dec_rtr[d], pix_valid[d], pix_last[d], err_timeout[d], dec_flags[d],
                 dec_pix_idx[d], pix_x[d], pix_y[d]} !== 15'b100_0000_0000_0000) begin
                fails++;
                $display("FAIL reset_ctrl dut%0d: got %b required 100000000000000", d,
                         {blk_ready[d], busy[d], dec_rtr[d], pix_valid[d], pix_last[d], err_timeout[d],
                          dec_flags[d], dec_pix_idx[d], pix_x[d], pix_y[d]});
            end
            checks++;
            if ({dec_block[d], pix_rgba[d]} !== 96'h0) begin
                fails++;
                $display("FAIL reset_data dut%0d: block=%h rgba=%h required 0", d, dec_block[d], pix_rgba[d]);
            end
        end
    endtask

    task automatic test_stream(input int d, input logic [63:0] b, input int latency);
        int base, ib;
        base = got.size();
        ib = idxs.size();
        lat[d] = latency;
        send_block(d, b, 1'b1);
        checks++;
        if (dec_block[d] !== b || dec_flags[d] !== 1'b1) begin
            fails++;
            $display("FAIL latch dut%0d: block=%h flags=%b required %h 1", d, dec_block[d], dec_flags[d], b);
        end
        wait_idle(d, 1000);
        checks++;
        if (!blk_ready[d] || cyc != last_acc_cyc + 1) begin
            fails++;
            $display("FAIL idle_after_last dut%0d: blk_ready=%b at cycle %0d, required 1 at %0d", d, blk_ready[d],
                     cyc, last_acc_cyc + 1);
        end
        checks++;
        if (got.size() - base != 16 || idxs.size() - ib != 16) begin
            fails++;
            $display("FAIL count dut%0d: pixels=%0d requests=%0d required 16", d, got.size() - base, idxs.size() - ib);
        end
        for (int n = 0; n < 16 && base + n < got.size() && ib + n < idxs.size(); n++) begin
            checks++;
            if (got[base + n] !== exp_pix(d, b, n) || int'(idxs[ib + n]) != exp_idx(d, n)) begin
                fails++;
                $display("FAIL pixel dut%0d n=%0d: got %h idx %0d required %h idx %0d", d, n, got[base + n],
                         idxs[ib + n], exp_pix(d, b, n), exp_idx(d, n));
            end
        end
    endtask

    task automatic test_back_pressure;
        int base;
        logic [63:0] b;
        logic [35:0] snap;
        b = {$urandom, $urandom};
        base = got.size();
        lat[0] = $urandom_range(1, 4);
        pix_ready[0] = 1'b0;
        send_block(0, b, 1'b0);
        for (int k = 0; k < 16; k++) begin
            wait_valid(0, 100);
            if (k == 3) begin
                snap = {pix_rgba[0], pix_x[0], pix_y[0]};
                for (int c = 0; c < 5; c++) begin
                    @(negedge sclk);
                    checks++;
                    if ({pix_rgba[0], pix_x[0], pix_y[0], pix_valid[0], dec_rtr[0]} !== {snap, 2'b10}) begin
                        fails++;
                        $display("FAIL hold c=%0d: got %h valid=%b rtr=%b required %h 1 0", c,
                                 {pix_rgba[0], pix_x[0], pix_y[0]}, pix_valid[0], dec_rtr[0], snap);
                    end
                end
            end
            @(posedge sclk); #1;
            pix_ready[0] = 1'b1;
            @(posedge sclk); #1;
            pix_ready[0] = 1'b0;
            if (k == 3) begin
                @(negedge sclk);
                checks++;
                if (!dec_rtr[0] || dec_pix_idx[0] !== 4'd1) begin
                    fails++;
                    $display("FAIL next_req: rtr=%b idx=%0d required 1 1", dec_rtr[0], dec_pix_idx[0]);
                end
            end
        end
        pix_ready[0] = 1'b1;
        wait_idle(0, 100);
        checks++;
        if (got.size() - base != 16) begin
            fails++;
            $display("FAIL bp_count: pixels=%0d required 16", got.size() - base);
        end
        for (int n = 0; n < 16 && base + n < got.size(); n++) begin
            checks++;
            if (got[base + n] !== exp_pix(0, b, n)) begin
                fails++;
                $display("FAIL bp_pixel n=%0d: got %h required %h", n, got[base + n], exp_pix(0, b, n));
            end
        end
    endtask

    task automatic test_timeout;
        int base, i;
        logic [63:0] b;
        b = {$urandom, $urandom};
        base = got.size();
        lat[0] = $urandom_range(1, 3);
        hang[0] = exp_idx(0, 7);
        send_block(0, b, 1'b0);
        for (i = 0; i < 500; i++) begin
            @(negedge sclk);
            if (err_timeout[0]) break;
        end
        checks++;
        if (!err_timeout[0] || cyc - rise_cyc[0] != 64 || idxs[idxs.size() - 1] !== 4'(hang[0])) begin
            fails++;
            $display("FAIL timeout_pulse: err=%b delay=%0d idx=%0d required 1 64 %0d", err_timeout[0],
                     cyc - rise_cyc[0], idxs[idxs.size() - 1], hang[0]);
        end
        checks++;
        if ({busy[0], blk_ready[0], dec_rtr[0]} !== 3'b010) begin
            fails++;
            $display("FAIL timeout_idle: busy/ready/rtr=%b required 010", {busy[0], blk_ready[0], dec_rtr[0]});
        end
        @(negedge sclk);
        checks++;
        if (err_timeout[0] !== 1'b0) begin
            fails++;
            $display("FAIL timeout_single: err=%b required 0", err_timeout[0]);
        end
        checks++;
        if (got.size() - base != 7) begin
            fails++;
            $display("FAIL timeout_count: pixels=%0d required 7", got.size() - base);
        end
        for (int n = 0; n < 7 && base + n < got.size(); n++) begin
            checks++;
            if (got[base + n] !== exp_pix(0, b, n)) begin
                fails++;
                $display("FAIL timeout_pixel n=%0d: got %h required %h", n, got[base + n], exp_pix(0, b, n));
            end
        end
        hang[0] = -1;
        test_stream(0, {$urandom, $urandom}, $urandom_range(1, 4));
    endtask

    task automatic test_spurious;
        int base;
        logic [31:0] snap;
        logic [63:0] a;
        a = {$urandom, $urandom};
        spur_col = 32'hdeadbeef;
        snap = pix_rgba[0];
        @(posedge sclk); #1 spur[0] = 1'b1;
        @(posedge sclk); #1 spur[0] = 1'b0;
        @(negedge sclk);
        checks++;
        if ({pix_valid[0], busy[0]} !== 2'b00 || pix_rgba[0] !== snap) begin
            fails++;
            $display("FAIL spur_idle: valid/busy=%b rgba=%h required 00 %h", {pix_valid[0], busy[0]}, pix_rgba[0], snap);
        end
        base = got.size();
        lat[0] = 2;
        pix_ready[0] = 1'b0;
        send_block(0, a, 1'b1);
        wait_valid(0, 100);
        snap = pix_rgba[0];
        @(posedge sclk); #1 spur[0] = 1'b1;
        checks++;
        if (blk_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready: blk_ready=%b required 0", blk_ready[0]);
        end
        send_block(0, ~a, 1'b0);
        spur[0] = 1'b0;
        @(negedge sclk);
        checks++;
        if (pix_rgba[0] !== snap || dec_block[0] !== a || dec_flags[0] !== 1'b1) begin
            fails++;
            $display("FAIL spur_out: rgba=%h block=%h flags=%b required %h %h 1", pix_rgba[0], dec_block[0],
                     dec_flags[0], snap, a);
        end
        pix_ready[0] = 1'b1;
        wait_idle(0, 200);
        checks++;
        if (got.size() - base != 16 || dec_block[0] !== a) begin
            fails++;
            $display("FAIL spur_count: pixels=%0d block=%h required 16 %h", got.size() - base, dec_block[0], a);
        end
        for (int n = 0; n < 16 && base + n < got.size(); n++) begin
            checks++;
            if (got[base + n] !== exp_pix(0, a, n)) begin
                fails++;
                $display("FAIL spur_pixel n=%0d: got %h required %h", n, got[base + n], exp_pix(0, a, n));
            end
        end
    endtask

    task automatic test_reset_mid;
        int i, ib;
        lat[0] = $urandom_range(2, 4);
        send_block(0, {$urandom, $urandom}, 1'b1);
        for (i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (dec_rtr[0] && dec_pix_idx[0] == 4'(exp_idx(0, 9))) break;
        end
        checks++;
        if (!dec_rtr[0] || dec_pix_idx[0] !== 4'(exp_idx(0, 9))) begin
            fails++;
            $display("FAIL reach_n9: rtr=%b idx=%0d required 1 %0d", dec_rtr[0], dec_pix_idx[0], exp_idx(0, 9));
        end
        #2 rsrt = 1'b0;
        #1;
        checks++;
        if ({blk_ready[0], busy[0], dec_rtr[0], pix_valid[0], pix_last[0], err_timeout[0], dec_flags[0],
             dec_pix_idx[0], pix_x[0], pix_y[0], dec_block[0], pix_rgba[0]} !== {15'b100_0000_0000_0000, 96'h0}) begin
            fails++;
            $display("FAIL async_reset: ctrl=%b block=%h rgba=%h required 100000000000000 0 0",
                     {blk_ready[0], busy[0], dec_rtr[0], pix_valid[0], pix_last[0], err_timeout[0], dec_flags[0],
                      dec_pix_idx[0], pix_x[0], pix_y[0]}, dec_block[0], pix_rgba[0]);
        end
        @(posedge sclk); #1;
        @(posedge sclk); #1 rsrt = 1'b1;
        ib = idxs.size();
        test_stream(0, {$urandom, $urandom}, $urandom_range(1, 4));
        checks++;
        if (idxs.size() <= ib || idxs[ib] !== 4'd0) begin
            fails++;
            $display("FAIL restart_idx: first request idx=%0d required 0", (idxs.size() > ib) ? idxs[ib] : 4'hf);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            blk_valid[d] = 1'b0;
            blk_data[d] = '0;
            blk_flags[d] = 1'b0;
            pix_ready[d] = 1'b1;
            lat[d] = 2;
            hang[d] = -1;
            spur[d] = 1'b0;
        end
        spur_col = '0;
        repeat (3) @(posedge sclk);
        #1;
        test_reset;
        rsrt = 1'b1;
        test_stream(0, 64'h5f91045b86f674a5, 2);
        test_stream(1, 64'h4554453200fef0e0, 3);
        test_back_pressure;
        test_timeout;
        test_spurious;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
